// File: rtl/spi_sample_scheduler_pkg.sv
// Shared state encoding and defaults for the two-channel SPI sample scheduler.
package spi_sample_scheduler_pkg;
  localparam int NCH             = 2;
  localparam int TIMEOUT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    CAPTURE   = 2'd3
  } state_e;
endpackage

// File: rtl/spi_sample_scheduler_timer.sv
// Auto-sample period timer: one tick every period+1 clocks, disabled when period is 0.
module sample_period_timer #(
  parameter int PERIOD_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                tick_o
);
  logic [PERIOD_W-1:0] cnt_q;

  // Compare against the live period so a new value applies at the next compare.
  assign tick_o = (period_i != '0) && (cnt_q == period_i);

  always_ff @(posedge clk) begin
    if (reset || period_i == '0 || tick_o) cnt_q <= '0;
    else                                   cnt_q <= cnt_q + PERIOD_W'(1);
  end
endmodule

// File: rtl/spi_sample_scheduler.sv
// Round-robin scheduler driving one input-only SPI master for two sample channels.
module spi_sample_scheduler
  import spi_sample_scheduler_pkg::*;
#(
  parameter int BITS     = 4,
  parameter int PERIOD_W = 8,
  parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] period,
  input  logic [NCH-1:0]      req,
  input  logic                clear_flags,
  input  logic                spi_cs,
  input  logic [BITS-1:0]     spi_data,
  output logic                spi_start,
  output logic [NCH-1:0]      cs_n,
  output logic [BITS-1:0]     sample0,
  output logic [BITS-1:0]     sample1,
  output logic [NCH-1:0]      sample_valid,
  output logic                busy,
  output logic [NCH-1:0]      overrun,
  output logic                timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e                    state_q;
  logic                      grant_q, last_grant_q, grant_d;
  logic                      spi_start_q, timeout_q, tick, expire;
  logic [TW-1:0]             tmo_q;
  logic [NCH-1:0]            pend_q, pend_d, ovr_q, ovr_d, valid_q;
  logic [NCH-1:0]            set_v, clr_v, elig;
  logic [NCH-1:0][BITS-1:0]  samp_q;

  sample_period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .period_i (period),
    .tick_o   (tick)
  );

  assign set_v  = req | {NCH{tick}};
  // Same-cycle requests are eligible so a request reaches spi_start in one clock.
  assign elig   = pend_q | set_v;
  assign expire = (state_q == WAIT_BUSY) && spi_cs && (tmo_q == TW'(1));

  always_comb begin
    clr_v = '0;
    if (state_q == CAPTURE || expire) clr_v[grant_q] = 1'b1;
  end

  // A set on a bit being cleared this cycle wins and is not an overrun.
  assign pend_d  = (pend_q & ~clr_v) | set_v;
  assign ovr_d   = (ovr_q & {NCH{~clear_flags}}) | (set_v & pend_q & ~clr_v);
  assign grant_d = (elig[0] && elig[1]) ? ~last_grant_q : elig[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      pend_q       <= '0;
      ovr_q        <= '0;
      timeout_q    <= 1'b0;
      spi_start_q  <= 1'b0;
      valid_q      <= '0;
      tmo_q        <= '0;
      samp_q       <= '0;
    end else begin
      pend_q      <= pend_d;
      ovr_q       <= ovr_d;
      timeout_q   <= (timeout_q & ~clear_flags) | expire;
      spi_start_q <= 1'b0;
      valid_q     <= '0;
      case (state_q)
        IDLE: if (|elig) begin
          grant_q     <= grant_d;
          spi_start_q <= 1'b1;
          tmo_q       <= TW'(TIMEOUT);
          state_q     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!spi_cs) state_q <= WAIT_DONE;
          else if (expire) begin
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end else tmo_q <= tmo_q - TW'(1);
        end
        WAIT_DONE: if (spi_cs) state_q <= CAPTURE;
        CAPTURE: begin
          samp_q[grant_q]  <= spi_data;
          valid_q[grant_q] <= 1'b1;
          last_grant_q     <= grant_q;
          state_q          <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    cs_n = '1;
    if (state_q != IDLE) cs_n[grant_q] = spi_cs;
  end

  assign spi_start    = spi_start_q;
  assign sample0      = samp_q[0];
  assign sample1      = samp_q[1];
  assign sample_valid = valid_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = ovr_q;
  assign timeout      = timeout_q;
endmodule

// File: doc/spi_sample_scheduler.md
Name: spi_sample_scheduler

Overview:
Sequences a single input-only SPI master on behalf of two sample channels, e.g. the process-variable sensor and the setpoint source of the PID loop. A programmable period timer and per-channel request pulses mark channels pending. A round-robin arbiter grants one channel, starts one transaction, steers the chip select and captures the result with a one-cycle valid strobe. It sits between the SPI master and the PID datapath.

Parameters:
BITS, 4, sample width; must equal the SPI master transfer width.
PERIOD_W, 8, width of the sample-period counter and the period input.
TIMEOUT, 4, cycles allowed for the SPI master to drop its chip select after a start pulse.

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
period  in  PERIOD_W  auto-sample period in clocks minus one; 0 disables the timer
req  in  2  per-channel manual sample request, pulse
clear_flags  in  1  clears the sticky overrun and timeout flags
spi_cs  in  1  chip select from the SPI master; low means transaction in progress
spi_data  in  BITS  SPI master output buffer
spi_start  out  1  one-cycle start pulse to the SPI master
cs_n  out  2  per-device chip selects
sample0  out  BITS  last captured channel-0 sample
sample1  out  BITS  last captured channel-1 sample
sample_valid  out  2  one-cycle pulse per channel on capture
busy  out  1  high whenever the state is not IDLE
overrun  out  2  sticky; a request hit an already-pending channel
timeout  out  1  sticky; the SPI master never went busy

Behaviour:
- Reset:
  - state=IDLE, tick counter=0, pending=00, last_grant=1 so channel 0 wins first.
  - spi_start=0, sample0=sample1=0, sample_valid=00, overrun=00, timeout=0, busy=0.
- Period timer:
  - If period!=0, the counter increments each cycle.
  - When counter==period it produces a tick and reloads to 0, so a tick occurs every period+1 clocks.
  - If period==0 the counter is held at 0 and no tick occurs.
  - A change of period takes effect at the next compare.
- Pending bits:
  - pending[i] is set by req[i] or by a tick; a tick sets both bits.
  - A set attempt on an already-pending bit sets overrun[i], except in the cycle the same bit is being cleared.
  - The clear in CAPTURE and a same-cycle set: set wins, and no overrun is flagged.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE, CAPTURE.
  - IDLE, any pending: grant the channel after last_grant in round-robin order. If only one is pending, grant that one. Register grant, drive spi_start=1 for exactly one cycle, go to WAIT_BUSY and load the timeout counter with TIMEOUT.
  - WAIT_BUSY, spi_cs==0: go to WAIT_DONE.
  - WAIT_BUSY, counter expires: set timeout, clear pending[grant], go to IDLE. The next grant still rotates.
  - WAIT_DONE, spi_cs==1: go to CAPTURE. spi_data is final in this cycle.
  - CAPTURE: load sample{grant} with spi_data, pulse sample_valid[grant] on the next cycle, clear pending[grant], set last_grant=grant, go to IDLE.
- Latency:
  - Request pulse to spi_start: 1 clock when IDLE.
  - Minimum gap between successive spi_start pulses: 4 clocks beyond the transaction.
- Chip-select steering (combinational):
  - cs_n[grant] = spi_cs whenever state!=IDLE; all other bits are 1.
  - In IDLE, cs_n = 11.
- clear_flags: clears overrun and timeout, but a same-cycle set wins.
- Reset mid-transaction:
  - All state returns to reset values immediately and cs_n=11.
  - The SPI master is expected to share the same reset.
- The sample registers hold their value until the next capture of their own channel.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=0, WAIT_BUSY=1, WAIT_DONE=2, CAPTURE=3);
  - NCH=2;
  - the default TIMEOUT.
- One sub-module: sample_period_timer, i.e. the counter plus tick with the period==0 disable.
- The arbiter and FSM stay in the top module.

Test Plan:
- Single request: period=0, pulse req=01, SPI model returns 4'hA after a 10-clock transaction. Expect:
  - spi_start one clock after req;
  - cs_n[0] low for the transfer, cs_n=11 afterwards;
  - sample0=A and sample_valid=01 for one cycle;
  - sample1 unchanged at 0.
- Round-robin: req=11 in one cycle. Expect:
  - channel 0 served first, then channel 1, with two spi_start pulses;
  - valid order 01 then 10;
  - overrun=00.
- Auto period: period=49, no req. Expect:
  - a tick every 50 clocks;
  - each tick produces two captures;
  - period=0 afterwards gives no further spi_start.
- Overrun: req=01 pulsed twice while channel 0 is pending or in transaction. Expect overrun=01; clear_flags returns it to 00.
- Timeout: the SPI model ignores start, so spi_cs stays 1. Expect:
  - timeout=1 after 4 clocks;
  - state back to IDLE and busy=0;
  - no sample_valid.
- Reset in WAIT_DONE: assert reset mid-transfer. Expect on the next clock:
  - cs_n=11, busy=0, pending=00, sample regs 0;
  - a fresh req still works afterwards.
